// File: rtl/mem_bus_responder.sv
// Purpose : memory-side responder for the CPU request/data-valid bus; one access at a time
//           against an internal word-organised RAM, with sign/zero-extended load data.
// Latency : request sampled at edge 0 -> o_bus_DV high in the cycle sampled by edge WAIT_STATES+2.
// Backpressure: o_busy=1 from acceptance through the response cycle; i_req ignored while busy.
//
// Ports   : i_clk, i_rst_n (sync, active-low), i_req/i_we/i_size/i_unsigned/i_addr/i_wdata
//           request side; o_bus_DV (one-cycle response pulse), o_rdata (held load data),
//           o_busy, o_err (valid with o_bus_DV).
// Option  : define MEM_BUS_RESP_ERR_EN to flag misaligned / out-of-range accesses on o_err
//           (no write, load data forced to 0). Without it, misaligned low address bits are
//           cleared, addresses wrap modulo the RAM size, and o_err stays 0.
module mem_bus_responder #(
   parameter int MEM_WORDS   = 4096,
   parameter int WAIT_STATES = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_bus_DV,
   output logic [31:0] o_rdata,
   output logic        o_busy,
   output logic        o_err
);

   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   // Contents deliberately have no reset: memory survives i_rst_n.
   logic [31:0] mem [MEM_WORDS];

   logic          is_byte;
   logic          is_half;
   logic [1:0]    off_d;
   logic [AW-1:0] idx_d;
   logic          acc_err_d;
   logic [31:0]   rword_d;
   logic [31:0]   rshift_d;
   logic [31:0]   load_d;
   logic [3:0]    lane_mask_d;
   logic [31:0]   wshift_d;
   logic          wr_en_d;

`ifdef MEM_BUS_RESP_ERR_EN
   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;
`else
   // Upper address bits only matter for range checking; they wrap away otherwise.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_q[31:AW+2];
`endif

   always_comb begin
      is_byte = (size_q == 2'b00);
      is_half = (size_q == 2'b01);
      idx_d   = addr_q[AW+1:2];

      // Lane offset: half accesses ignore addr[0], word accesses ignore addr[1:0].
      if (is_byte) begin
         off_d = addr_q[1:0];
      end else if (is_half) begin
         off_d = {addr_q[1], 1'b0};
      end else begin
         off_d = 2'b00;
      end

`ifdef MEM_BUS_RESP_ERR_EN
      acc_err_d = (is_half && addr_q[0])
               || (!is_byte && !is_half && (addr_q[1:0] != 2'b00))
               || ({1'b0, addr_q} >= ADDR_LIMIT);
`else
      acc_err_d = 1'b0;
`endif

      rword_d  = mem[idx_d];
      rshift_d = rword_d >> {off_d, 3'b000};

      if (is_byte) begin
         load_d = uns_q ? {24'h0, rshift_d[7:0]} : {{24{rshift_d[7]}}, rshift_d[7:0]};
      end else if (is_half) begin
         load_d = uns_q ? {16'h0, rshift_d[15:0]} : {{16{rshift_d[15]}}, rshift_d[15:0]};
      end else begin
         load_d = rshift_d;
      end
      if (acc_err_d) begin
         load_d = 32'h0;
      end

      if (is_byte) begin
         lane_mask_d = 4'b0001 << off_d;
      end else if (is_half) begin
         lane_mask_d = 4'b0011 << off_d;
      end else begin
         lane_mask_d = 4'b1111;
      end
      wshift_d = wdata_q << {off_d, 3'b000};

      // A reset landing on the ACCESS edge must suppress the write.
      wr_en_d = (state_q == S_ACCESS) && we_q && !acc_err_d && i_rst_n;
   end

   always_ff @(posedge i_clk) begin
      if (wr_en_d) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_mask_d[b]) begin
               mem[idx_d][8*b +: 8] <= wshift_d[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         uns_q    <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         o_bus_DV <= 1'b0;
         o_rdata  <= 32'h0;
         o_busy   <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         o_bus_DV <= 1'b0;
         o_err    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_req) begin
                  we_q    <= i_we;
                  size_q  <= i_size;
                  uns_q   <= i_unsigned;
                  addr_q  <= i_addr;
                  wdata_q <= i_wdata;
                  cnt_q   <= 4'(WAIT_STATES);
                  o_busy  <= 1'b1;
                  state_q <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
               end
            end
            S_WAIT: begin
               // WAIT lasts exactly WAIT_STATES cycles: leave as the count hits 0.
               if (cnt_q <= 4'd1) begin
                  cnt_q   <= 4'd0;
                  state_q <= S_ACCESS;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_ACCESS: begin
               if (!we_q) begin
                  o_rdata <= load_d;
               end
               o_err    <= acc_err_d;
               o_bus_DV <= 1'b1;
               state_q  <= S_RESP;
            end
            default: begin
               o_busy  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
